// File: rtl/gam_winner_search.sv
// gam_winner_search: walks every stored node of one class through the GAM
// read port and accumulates the squared Euclidean distance one element per
// cycle. It reports the nearest and second-nearest nodes, and flags when the
// input lies outside the winner's threshold so that a new node is needed.

package GAM_package;
   typedef enum logic {READ = 1'b0, WRITE = 1'b1} RD_WR_T;
endpackage

module gam_winner_search
   import GAM_package::*;
#(
   parameter int DIM       = 8,
   parameter int MAX_NODES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [31:0]      class_sel,
   input  logic signed [31:0]      num_nodes,
   input  logic [DIM-1:0][31:0]    X_in,
   output logic                    busy,
   output logic                    done,
   output logic signed [31:0]      winner_idx,
   output logic signed [31:0]      second_idx,
   output logic [63:0]             winner_dist,
   output logic [63:0]             second_dist,
   output logic                    new_node,
   output logic signed [31:0]      class_o,
   output logic signed [31:0]      node_o,
   output logic                    X_c,
   output logic                    C_c,
   output logic                    M_c,
   output logic                    W_c,
   output logic                    T_c,
   output RD_WR_T                  RD_WR_c,
   input  logic [DIM-1:0][31:0]    W_i,
   input  logic signed [31:0]      Th_i
);

   typedef enum logic [2:0] {IDLE, LOAD, ACC, CMP, DONE} state_t;

   localparam int              EW        = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [EW-1:0]   ELEM_LAST = EW'(DIM - 1);
   localparam logic [63:0]     DIST_MAX  = '1;

   state_t                  state_reg;
   logic signed [31:0]      class_reg;
   logic signed [31:0]      n_reg;
   logic signed [31:0]      node_reg;
   logic [EW-1:0]           elem_reg;
   logic [DIM-1:0][31:0]    x_reg;
   logic [DIM-1:0][31:0]    w_reg;
   logic signed [31:0]      th_reg;
   logic [63:0]             acc_reg;

   // running trackers, published to the result outputs only in DONE
   logic signed [31:0]      best_idx_reg;
   logic [63:0]             best_dist_reg;
   logic signed [31:0]      best_th_reg;
   logic signed [31:0]      sec_idx_reg;
   logic [63:0]             sec_dist_reg;

   logic                    busy_reg;
   logic                    done_reg;
   logic                    rd_en_reg;
   logic signed [31:0]      node_o_reg;
   logic signed [31:0]      winner_idx_reg;
   logic signed [31:0]      second_idx_reg;
   logic [63:0]             winner_dist_reg;
   logic [63:0]             second_dist_reg;
   logic                    new_node_reg;

   logic signed [31:0]      n_clamped;
   logic signed [31:0]      node_inc;
   logic signed [31:0]      x_e;
   logic signed [31:0]      w_e;
   logic signed [32:0]      diff;
   logic signed [32:0]      diff_neg;
   logic [31:0]             diff_mag;
   logic [63:0]             diff_sq;
   logic [64:0]             acc_sum;
   logic [63:0]             acc_next;
   logic [31:0]             th_mag;
   logic [63:0]             th_sq;

   // clamp the requested node count into 0..MAX_NODES
   always_comb begin
      if (num_nodes < 0)
         n_clamped = '0;
      else if (num_nodes > MAX_NODES)
         n_clamped = MAX_NODES;
      else
         n_clamped = num_nodes;
   end

   // one-element distance step; |x-w| never exceeds 2^32-1 so its square fits 64 bits,
   // and the accumulator saturates instead of wrapping
   always_comb begin
      node_inc = node_reg + 32'sd1;
      x_e      = x_reg[elem_reg];
      w_e      = w_reg[elem_reg];
      diff     = {x_e[31], x_e} - {w_e[31], w_e};
      diff_neg = -diff;
      diff_mag = diff[32] ? diff_neg[31:0] : diff[31:0];
      diff_sq  = {32'd0, diff_mag} * {32'd0, diff_mag};
      acc_sum  = {1'b0, acc_reg} + {1'b0, diff_sq};
      acc_next = acc_sum[64] ? DIST_MAX : acc_sum[63:0];
      th_mag   = best_th_reg[31] ? 32'd0 : best_th_reg;
      th_sq    = {32'd0, th_mag} * {32'd0, th_mag};
   end

   // search sequencer: IDLE -> (LOAD -> ACC x DIM -> CMP) per node -> DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         class_reg       <= '0;
         n_reg           <= '0;
         node_reg        <= '0;
         elem_reg        <= '0;
         x_reg           <= '0;
         w_reg           <= '0;
         th_reg          <= '0;
         acc_reg         <= '0;
         best_idx_reg    <= -1;
         best_dist_reg   <= DIST_MAX;
         best_th_reg     <= '0;
         sec_idx_reg     <= -1;
         sec_dist_reg    <= DIST_MAX;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         rd_en_reg       <= 1'b0;
         node_o_reg      <= '0;
         winner_idx_reg  <= -1;
         second_idx_reg  <= -1;
         winner_dist_reg <= DIST_MAX;
         second_dist_reg <= DIST_MAX;
         new_node_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  class_reg     <= class_sel;
                  x_reg         <= X_in;
                  n_reg         <= n_clamped;
                  node_reg      <= '0;
                  best_idx_reg  <= -1;
                  best_dist_reg <= DIST_MAX;
                  best_th_reg   <= '0;
                  sec_idx_reg   <= -1;
                  sec_dist_reg  <= DIST_MAX;
                  busy_reg      <= 1'b1;
                  if (n_clamped > 0) begin
                     state_reg  <= LOAD;
                     node_o_reg <= '0;
                     rd_en_reg  <= 1'b1;
                  end else begin
                     state_reg  <= DONE;
                  end
               end
            end
            LOAD: begin
               // memory answers combinationally to the address driven this cycle
               w_reg     <= W_i;
               th_reg    <= Th_i;
               acc_reg   <= '0;
               elem_reg  <= '0;
               rd_en_reg <= 1'b0;
               state_reg <= ACC;
            end
            ACC: begin
               acc_reg <= acc_next;
               if (elem_reg == ELEM_LAST)
                  state_reg <= CMP;
               else
                  elem_reg <= elem_reg + 1'b1;
            end
            CMP: begin
               // strict compares: on a tie the earlier (lower) index is kept
               if (acc_reg < best_dist_reg) begin
                  sec_idx_reg   <= best_idx_reg;
                  sec_dist_reg  <= best_dist_reg;
                  best_idx_reg  <= node_reg;
                  best_dist_reg <= acc_reg;
                  best_th_reg   <= th_reg;
               end else if (acc_reg < sec_dist_reg) begin
                  sec_idx_reg   <= node_reg;
                  sec_dist_reg  <= acc_reg;
               end
               node_reg <= node_inc;
               if (node_inc < n_reg) begin
                  state_reg  <= LOAD;
                  node_o_reg <= node_inc;
                  rd_en_reg  <= 1'b1;
               end else begin
                  state_reg  <= DONE;
               end
            end
            DONE: begin
               winner_idx_reg  <= best_idx_reg;
               second_idx_reg  <= sec_idx_reg;
               winner_dist_reg <= best_dist_reg;
               second_dist_reg <= sec_dist_reg;
               new_node_reg    <= (best_idx_reg < 0) || (best_dist_reg > th_sq);
               done_reg        <= 1'b1;
               busy_reg        <= 1'b0;
               state_reg       <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign winner_idx  = winner_idx_reg;
   assign second_idx  = second_idx_reg;
   assign winner_dist = winner_dist_reg;
   assign second_dist = second_dist_reg;
   assign new_node    = new_node_reg;
   assign class_o     = class_reg;
   assign node_o      = node_o_reg;
   assign W_c         = rd_en_reg;
   assign T_c         = rd_en_reg;
   assign X_c         = 1'b0;
   assign C_c         = 1'b0;
   assign M_c         = 1'b0;
   assign RD_WR_c     = READ;

endmodule

// File: tb/tb_gam_winner_search.sv
// Testbench for gam_winner_search: a small behavioural GAM memory answers the
// read port, and a table of directed searches with hand-computed winners is
// replayed, followed by busy-start, mid-search reset and restart sequences.

module tb_gam_winner_search;
   import GAM_package::*;

   localparam int DIM  = 4;
   localparam int MAXN = 16;
   localparam int NVEC = 11;
   localparam logic [63:0] DMAX = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam int MAXI = 32'h7FFF_FFFF;
   localparam int MINI = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start;
   logic signed [31:0] class_sel, num_nodes;
   logic [DIM-1:0][31:0] x_in;
   logic busy, done, new_node;
   logic signed [31:0] winner_idx, second_idx, class_o, node_o;
   logic [63:0] winner_dist, second_dist;
   logic x_c, c_c, m_c, w_c, t_c;
   RD_WR_T rd_wr_c;
   logic [DIM-1:0][31:0] w_i;
   logic signed [31:0] th_i;

   logic [DIM-1:0][31:0] mem_w [MAXN];
   logic signed [31:0]   mem_th [MAXN];

   int n_vec = 0;
   int n_miss = 0;
   int n_checks = 0;
   int last_win = -1;

   typedef struct {
      logic [3:0][DIM-1:0][31:0] w;
      logic [3:0][31:0]          th;
      logic [DIM-1:0][31:0]      x;
      int                        n;
      int                        n_eff;
      int                        win;
      int                        sec;
      logic [63:0]               wd;
      logic [63:0]               sd;
      logic                      nn;
   } vec_t;

   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   // combinational read port, as the real memory behaves
   assign w_i  = mem_w[node_o[3:0]];
   assign th_i = mem_th[node_o[3:0]];

   gam_winner_search #(.DIM(DIM), .MAX_NODES(MAXN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .class_sel(class_sel),
      .num_nodes(num_nodes), .X_in(x_in), .busy(busy), .done(done),
      .winner_idx(winner_idx), .second_idx(second_idx),
      .winner_dist(winner_dist), .second_dist(second_dist),
      .new_node(new_node), .class_o(class_o), .node_o(node_o),
      .X_c(x_c), .C_c(c_c), .M_c(m_c), .W_c(w_c), .T_c(t_c),
      .RD_WR_c(rd_wr_c), .W_i(w_i), .Th_i(th_i)
   );

   function automatic logic [DIM-1:0][31:0] v4(int a, int b, int c, int d);
      return {d, c, b, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_win"}, winner_idx, -1);
      chk({tag, "_sec"}, second_idx, -1);
      chk({tag, "_wd"}, winner_dist, DMAX);
      chk({tag, "_sd"}, second_dist, DMAX);
      chk({tag, "_new"}, new_node, 1'b0);
      chk({tag, "_class"}, class_o, 0);
      chk({tag, "_node"}, node_o, 0);
      chk({tag, "_wt"}, {w_c, t_c, x_c, c_c, m_c}, 5'b0);
      chk({tag, "_rdwr"}, rd_wr_c, READ);
   endtask

   task automatic load_mem(input vec_t v);
      for (int j = 0; j < MAXN; j++) begin
         mem_w[j]  = (j < 4) ? v.w[j] : v4(100, 100, 100, 100);
         mem_th[j] = (j < 4) ? v.th[j] : 0;
      end
   endtask

   // run one search; glitch > 0 pulses start (with other data) at that cycle
   task automatic run_vec(input int id, input vec_t v, input int glitch);
      int cyc, wc, lat;
      lat = 1 + v.n_eff * (DIM + 2);
      load_mem(v);
      @(negedge clk);
      class_sel = id + 1;
      num_nodes = v.n;
      x_in      = v.x;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      wc  = w_c ? 1 : 0;
      while (!done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (w_c) wc++;
         if (cyc == 1 && lat > 1) chk("busy_mid", busy, 1'b1);
         if (cyc == 3 && lat > 3) chk("hold_win", winner_idx, last_win);
         if (glitch > 0 && cyc == glitch) begin
            start     = 1'b1;
            num_nodes = 1;
            x_in      = v4(10, 10, 10, 10);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("latency", cyc, lat);
      chk("winner_idx", winner_idx, v.win);
      chk("second_idx", second_idx, v.sec);
      chk("winner_dist", winner_dist, v.wd);
      chk("second_dist", second_dist, v.sd);
      chk("new_node", new_node, v.nn);
      chk("load_count", wc, v.n_eff);
      chk("busy_at_done", busy, 1'b0);
      chk("class_o", class_o, id + 1);
      $display("vec %0d: N=%0d lat=%0d win=%0d dist=%0h sec=%0d dist=%0h new=%0b checks=%0d",
               id, v.n, cyc, winner_idx, winner_dist, second_idx, second_dist, new_node, n_checks);
      @(posedge clk);
      #1;
      chk("done_pulse", done, 1'b0);
      last_win = v.win;
      n_vec++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn;
      start = 1'b0; class_sel = 0; num_nodes = 0; x_in = '0;
      for (int i = 0; i < NVEC; i++) begin
         vecs[i].w = '0; vecs[i].th = '0; vecs[i].x = '0;
      end
      // test-plan memory
      vecs[0].w[0] = v4(0, 0, 0, 0); vecs[0].th[0] = 3;
      vecs[0].w[1] = v4(5, 5, 5, 5); vecs[0].th[1] = 5;
      vecs[0].w[2] = v4(1, 1, 1, 1); vecs[0].th[2] = 0;
      vecs[0].w[3] = v4(9, 9, 9, 9); vecs[0].th[3] = 0;
      vecs[0].x = v4(1, 1, 1, 1); vecs[0].n = 3; vecs[0].n_eff = 3;
      vecs[0].win = 2; vecs[0].wd = 0; vecs[0].sec = 0; vecs[0].sd = 4; vecs[0].nn = 0;
      vecs[1] = vecs[0];
      vecs[1].x = v4(10, 10, 10, 10);
      vecs[1].win = 1; vecs[1].wd = 100; vecs[1].sec = 2; vecs[1].sd = 324; vecs[1].nn = 1;
      vecs[2] = vecs[0];
      vecs[2].n = 0; vecs[2].n_eff = 0;
      vecs[2].win = -1; vecs[2].wd = DMAX; vecs[2].sec = -1; vecs[2].sd = DMAX; vecs[2].nn = 1;
      vecs[3] = vecs[2];
      vecs[3].n = -5;
      // tie: nodes 0 and 1 equal to X
      vecs[4].w[0] = v4(7, -3, 2, 0); vecs[4].w[1] = v4(7, -3, 2, 0);
      vecs[4].x = v4(7, -3, 2, 0); vecs[4].n = 3; vecs[4].n_eff = 3;
      vecs[4].win = 0; vecs[4].wd = 0; vecs[4].sec = 1; vecs[4].sd = 0; vecs[4].nn = 0;
      // single node
      vecs[5] = vecs[0];
      vecs[5].n = 1; vecs[5].n_eff = 1;
      vecs[5].win = 0; vecs[5].wd = 4; vecs[5].sec = -1; vecs[5].sd = DMAX; vecs[5].nn = 0;
      // negative threshold counts as 0
      vecs[6].th[0] = -2; vecs[6].x = v4(1, 0, 0, 0); vecs[6].n = 1; vecs[6].n_eff = 1;
      vecs[6].win = 0; vecs[6].wd = 1; vecs[6].sec = -1; vecs[6].sd = DMAX; vecs[6].nn = 1;
      // one full-range element: (2^32-1)^2, no overflow
      vecs[7].w[0] = v4(MINI, 0, 0, 0); vecs[7].th[0] = MAXI;
      vecs[7].x = v4(MAXI, 0, 0, 0); vecs[7].n = 1; vecs[7].n_eff = 1;
      vecs[7].win = 0; vecs[7].wd = 64'hFFFF_FFFE_0000_0001;
      vecs[7].sec = -1; vecs[7].sd = DMAX; vecs[7].nn = 1;
      // two full-range elements saturate node 0, so it can never win
      vecs[8].w[0] = v4(MINI, MINI, 0, 0); vecs[8].w[1] = v4(0, 0, 0, 0);
      vecs[8].x = v4(MAXI, MAXI, 0, 0); vecs[8].n = 2; vecs[8].n_eff = 2;
      vecs[8].win = 1; vecs[8].wd = 64'h7FFF_FFFE_0000_0002;
      vecs[8].sec = -1; vecs[8].sd = DMAX; vecs[8].nn = 1;
      // num_nodes above MAX_NODES is clamped; nodes 4.. hold (100,100,100,100)
      vecs[9] = vecs[0];
      vecs[9].x = v4(100, 100, 100, 100); vecs[9].n = 20; vecs[9].n_eff = 16;
      vecs[9].win = 4; vecs[9].wd = 0; vecs[9].sec = 5; vecs[9].sd = 0; vecs[9].nn = 0;
      // signed elements: 36+64+100+144 = 344 > 10^2
      vecs[10].w[0] = v4(-3, 4, -5, 6); vecs[10].th[0] = 10;
      vecs[10].x = v4(3, -4, 5, -6); vecs[10].n = 1; vecs[10].n_eff = 1;
      vecs[10].win = 0; vecs[10].wd = 344; vecs[10].sec = -1; vecs[10].sd = DMAX; vecs[10].nn = 1;

      load_mem(vecs[0]);
      #2 rst_n = 1'b0;
      #1;
      chk_reset("rst_assert");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_reset("rst_release");
      $display("vec reset: outputs at reset values checks=%0d", n_checks);
      n_vec++;

      for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i], 0);

      // start pulsed while busy must not disturb the running search
      run_vec(20, vecs[0], 5);

      // reset during ACC of node 1 aborts with no done
      load_mem(vecs[1]);
      @(negedge clk);
      class_sel = 9; num_nodes = 3; x_in = vecs[1].x; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("abort_busy", busy, 1'b1);
      chk("abort_node", node_o, 1);
      rst_n = 1'b0;
      #1;
      chk_reset("rst_mid");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done || busy) dn++;
      end
      chk("no_done_after_abort", dn, 0);
      $display("vec abort: reset mid-search checks=%0d", n_checks);
      n_vec++;
      last_win = -1;

      // a fresh search after the abort completes normally
      run_vec(21, vecs[1], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
